hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The module SHALL have parameter MUL_LAT, default 4, giving the cycles from operand presentation to a valid mul_z; the legal range SHALL be 1..15.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 valid  input  1  request strobe for op, sampled on the rising edge.
REQ-005 op  input  3  operation: 3'd0 NONE, 3'd1 MULTU, 3'd2 MULT, 3'd3 MTHI, 3'd4 MTLO; any other value SHALL act as NONE.
REQ-006 rs_data  input  32  first operand, or the value for MTHI/MTLO.
REQ-007 rt_data  input  32  second operand.
REQ-008 mul_a  output  32  operand driven to the downstream unsigned multiplier's a input.
REQ-009 mul_b  output  32  operand driven to the multiplier's b input.
REQ-010 mul_z  input  64  unsigned product returned by the multiplier.
REQ-011 busy  output  1  high while a multiply is in flight; upstream SHALL stall while it is high.
REQ-012 done  output  1  one-cycle pulse in the cycle that hi/lo capture a product.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.
REQ-015 err  output  1  one-cycle pulse when an unsupported op is accepted (see Configuration).

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and WRITE.
REQ-017 In IDLE, valid with MULTU or MULT SHALL latch the operands into mul_a/mul_b, load the counter with MUL_LAT-1 and move to WAIT.
REQ-018 For MULT, mul_a/mul_b SHALL be the absolute values of rs_data/rt_data, with 0x80000000 passed unchanged, and a neg flag SHALL be set to the XOR of the two sign bits.
REQ-019 mul_a and mul_b SHALL hold stable from acceptance until the state leaves WRITE.
REQ-020 In WAIT, the counter SHALL decrement every cycle, and the state SHALL move to WRITE on the cycle the counter equals 0.
REQ-021 In WRITE, done SHALL be 1, {hi,lo} SHALL load mul_z (two's-complement negated over 64 bits when neg=1) at the closing edge, and the state SHALL return to IDLE.
REQ-022 busy SHALL be 1 in WAIT and WRITE, and 0 in IDLE.
REQ-023 Latency: a request accepted at edge N SHALL make new hi/lo visible after edge N+MUL_LAT+1, and a new request SHALL be accepted no earlier than edge N+MUL_LAT+1.
REQ-024 With MUL_LAT=1, WAIT SHALL last exactly one cycle.
REQ-025 In IDLE, MTHI/MTLO SHALL write rs_data into hi/lo at the next edge, with busy remaining 0.
REQ-026 Any request arriving while busy=1 SHALL be ignored, with no state change and no err.
REQ-027 A multiply SHALL write both hi and lo; no other op SHALL alter the register it does not name.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, counter=0, neg=0, mul_a=mul_b=0, hi=lo=0, busy=done=err=0.
REQ-029 Reset asserted mid-multiply SHALL abandon the operation with no hi/lo update and no done pulse.
REQ-030 The first request SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-031 Macro HILO_SIGNED_EN defined SHALL enable MULT as specified in REQ-017/REQ-018.
REQ-032 With HILO_SIGNED_EN undefined, MULT SHALL act as NONE, err SHALL pulse one cycle after acceptance, no neg logic SHALL be built, and hi/lo SHALL be unchanged.

Verification
REQ-033 The bench SHALL include a multiplier model of MUL_LAT=4 cycles, and each scenario below SHALL pass against it.
REQ-034 MULTU with rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 5 cycles, done pulses once, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 MULT with rs=0xFFFFFFFD (-3), rt=0x00000005 -> mul_a=3, mul_b=5, hi=0xFFFFFFFF, lo=0xFFFFFFF1; with HILO_SIGNED_EN undefined -> err pulse, hi/lo unchanged.
REQ-036 MULT with rs=0x80000000, rt=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
REQ-037 MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never high.
REQ-038 MTLO issued 2 cycles after a MULTU 2x3 -> MTLO ignored, lo=6, hi=0; reset pulsed during WAIT of a second multiply -> hi=lo=0, no done pulse, busy=0 immediately.

Source files
------------

// File: rtl/hilo_if.sv
// hilo_if: request, result and multiplier-port bundle for hilo_unit.
// slave is the unit side; master is the requester/multiplier side.
interface hilo_if;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  modport slave (
    input  valid, op, rs_data, rt_data, mul_z,
    output mul_a, mul_b, busy, done, hi, lo, err
  );

  modport master (
    output valid, op, rs_data, rt_data, mul_z,
    input  mul_a, mul_b, busy, done, hi, lo, err
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO registers sequencing an external MUL_LAT-cycle multiplier.
// Define HILO_SIGNED_EN to build signed MULT; otherwise MULT raises err.
module hilo_unit #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic  clk,
  input  logic  reset,
  hilo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_err;

  logic        w_acc;
  logic        w_mulu;
  logic        w_mult;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_start;
  logic        w_err;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [63:0] w_prod;

  assign w_acc  = bus.valid && (r_state == IDLE);
  assign w_mulu = w_acc && (bus.op == OP_MULTU);
  assign w_mult = w_acc && (bus.op == OP_MULT);
  assign w_mthi = w_acc && (bus.op == OP_MTHI);
  assign w_mtlo = w_acc && (bus.op == OP_MTLO);

`ifdef HILO_SIGNED_EN
  logic r_neg;

  // Magnitudes go to the unsigned multiplier; 0x80000000 negates to itself.
  assign w_start = w_mulu | w_mult;
  assign w_a     = (w_mult && bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
  assign w_b     = (w_mult && bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;
  assign w_prod  = r_neg ? -bus.mul_z : bus.mul_z;
  assign w_err   = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= w_mult & (bus.rs_data[31] ^ bus.rt_data[31]);
    end
  end
`else
  assign w_start = w_mulu;
  assign w_a     = bus.rs_data;
  assign w_b     = bus.rt_data;
  assign w_prod  = bus.mul_z;
  assign w_err   = w_mult;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE:    w_busy = 1'b0;
      WAIT:    w_busy = 1'b1;
      WRITE:   begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_start) begin
        r_cnt <= CNT_INIT;
        r_a   <= w_a;
        r_b   <= w_b;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == WRITE) begin
      {r_hi, r_lo} <= w_prod;
    end else if (w_mthi) begin
      r_hi <= bus.rs_data;
    end else if (w_mtlo) begin
      r_lo <= bus.rs_data;
    end
  end

  assign bus.mul_a = r_a;
  assign bus.mul_b = r_b;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scoreboard bench for hilo_unit with a 4-cycle multiplier.
// Follows HILO_SIGNED_EN the same way the design build does.
module tb_hilo_unit;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hilo_if bus();

  hilo_unit #(.MUL_LAT(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mul_z = pipe[L-1];

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  int   run = 0;
  bit   pend = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!reset) begin
      run  = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("done_hi", bus.hi, cur.hi);
        chk("done_lo", bus.lo, cur.lo);
        pend = 0;
      end
      run = bus.busy ? run + 1 : 0;
      if (bus.done) begin
        if (sb.size() == 0 || sb[0].is_err) begin
          chk("stray_done", bus.done, 0);
        end else begin
          cur = sb.pop_front();
          chk("busy_len", run, L + 1);
          chk("mul_a", bus.mul_a, cur.a);
          chk("mul_b", bus.mul_b, cur.b);
          pend = 1;
        end
      end
      if (bus.err) begin
        if (sb.size() == 0 || !sb[0].is_err) begin
          chk("stray_err", bus.err, 0);
        end else begin
          cur = sb.pop_front();
          chk("err_hi", bus.hi, cur.hi);
          chk("err_lo", bus.lo, cur.lo);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic drive(logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
    bus.valid   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(negedge clk);
    bus.valid   = 1'b0;
    bus.op      = 3'd0;
  endtask

  task automatic do_op(logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
    exp_t        e;
    logic [63:0] p;
    longint      sa;
    longint      sb_v;
    bit          is_mul;
    wait_idle();
    is_mul = 0;
    if (op == 3'd1) begin
      p    = {32'd0, rs} * {32'd0, rt};
      m_hi = p[63:32];
      m_lo = p[31:0];
      e    = '{0, rs, rt, m_hi, m_lo};
      sb.push_back(e);
      is_mul = 1;
    end else if (op == 3'd2) begin
`ifdef HILO_SIGNED_EN
      sa   = longint'($signed(rs));
      sb_v = longint'($signed(rt));
      p    = 64'(sa * sb_v);
      m_hi = p[63:32];
      m_lo = p[31:0];
      sa   = (sa < 0) ? -sa : sa;
      sb_v = (sb_v < 0) ? -sb_v : sb_v;
      e    = '{0, 32'(sa), 32'(sb_v), m_hi, m_lo};
      sb.push_back(e);
      is_mul = 1;
`else
      sa   = 0;
      sb_v = 0;
      e    = '{1, 32'd0, 32'd0, m_hi, m_lo};
      sb.push_back(e);
`endif
    end else if (op == 3'd3) begin
      m_hi = rs;
    end else if (op == 3'd4) begin
      m_lo = rs;
    end
    drive(op, rs, rt);
    if (!is_mul) begin
      chk("nonmul_busy", bus.busy, 0);
      chk("nonmul_hi", bus.hi, m_hi);
      chk("nonmul_lo", bus.lo, m_lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    bus.valid   = 1'b0;
    bus.op      = 3'd0;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    #12;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    @(negedge clk);
    reset = 1'b1;

    do_op(3'd1, 32'd2, 32'd3);
    @(negedge clk);
    drive(3'd4, 32'hDEAD_BEEF, 32'd0);
    wait_idle();
    chk("ign_lo", bus.lo, 32'd6);
    chk("ign_hi", bus.hi, 32'd0);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    chk("max_hi", bus.hi, 32'hFFFF_FFFE);
    chk("max_lo", bus.lo, 32'h0000_0001);

    do_op(3'd2, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
`ifdef HILO_SIGNED_EN
    chk("neg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("neg_lo", bus.lo, 32'hFFFF_FFF1);
`else
    chk("nosgn_hi", bus.hi, 32'hFFFF_FFFE);
    chk("nosgn_lo", bus.lo, 32'h0000_0001);
`endif

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
`ifdef HILO_SIGNED_EN
    chk("min_hi", bus.hi, 32'h0000_0000);
    chk("min_lo", bus.lo, 32'h8000_0000);
`endif

    do_op(3'd3, 32'h1234_5678, 32'd0);
    do_op(3'd4, 32'h9ABC_DEF0, 32'd0);
    chk("mt_hi", bus.hi, 32'h1234_5678);
    chk("mt_lo", bus.lo, 32'h9ABC_DEF0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom();
      rt = $urandom();
      if ($urandom_range(0, 3) == 0) rs = {28'd0, rs[3:0]};
      if ($urandom_range(0, 3) == 0) rt = 32'h8000_0000;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(op, rs, rt);
    end

    do_op(3'd1, 32'd7, 32'd9);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b1;
    do_op(3'd3, 32'hCAFE_F00D, 32'd0);
    repeat (L + 3) @(negedge clk);
    chk("post_rst_hi", bus.hi, 32'hCAFE_F00D);
    chk("post_rst_lo", bus.lo, 32'd0);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
